// File: rtl/fphub_pkg.sv
// Shared types and helpers for the HUB floating-point adder slice.
// Latency: n/a (types, constants and pure functions only).
// Backpressure: n/a.
package fphub_pkg;

  // Operand formats understood by the unit.
  typedef enum logic [2:0] {
    FP32    = 3'd0,
    FP64    = 3'd1,
    FP16    = 3'd2,
    FP8     = 3'd3,
    FP16ALT = 3'd4
  } fp_format_e;

  // Operation group encoding; only ADD is executed by this unit.
  typedef enum logic [3:0] {
    FMADD, FNMSUB, ADD, MUL, DIV, SQRT, SGNJ, MINMAX,
    CMP, CLASSIFY, F2F, F2I, I2F, CPKAB, CPKCD
  } operation_e;

  // Exception flags, NV in the MSB.
  typedef struct packed {
    logic NV;
    logic DZ;
    logic OF;
    logic UF;
    logic NX;
  } status_t;

  // Stage payload in the default FP16 / 4-bit-tag configuration.
  typedef struct packed {
    logic [15:0] result;
    status_t     status;
    logic [3:0]  tag;
  } fphub_stage_t;

  function automatic int exp_bits(input fp_format_e fmt);
    case (fmt)
      FP32:    return 8;
      FP64:    return 11;
      FP16:    return 5;
      FP8:     return 5;
      FP16ALT: return 8;
      default: return 5;
    endcase
  endfunction

  function automatic int man_bits(input fp_format_e fmt);
    case (fmt)
      FP32:    return 23;
      FP64:    return 52;
      FP16:    return 10;
      FP8:     return 2;
      FP16ALT: return 7;
      default: return 10;
    endcase
  endfunction

  // Canonical quiet NaN: sign 0, exponent all ones, mantissa MSB set.
  function automatic logic [63:0] canon_nan(input int e, input int m);
    logic [63:0] emask;
    emask = ((64'd1 << e) - 64'd1) << m;
    return emask | (64'd1 << (m - 1));
  endfunction

  // Helpers take the operand zero-extended to 64 bits plus its field widths.
  function automatic logic exp_ones(input logic [63:0] v, input int e, input int m);
    logic [63:0] emask;
    emask = ((64'd1 << e) - 64'd1) << m;
    return (v & emask) == emask;
  endfunction

  function automatic logic is_inf(input logic [63:0] v, input int e, input int m);
    return exp_ones(v, e, m) && ((v & ((64'd1 << m) - 64'd1)) == 64'd0);
  endfunction

  function automatic logic is_nan(input logic [63:0] v, input int e, input int m);
    return exp_ones(v, e, m) && ((v & ((64'd1 << m) - 64'd1)) != 64'd0);
  endfunction

endpackage

// File: rtl/fphub_add_pipe_if.sv
// Operation/result bundle of the pipelined HUB adder.
// Latency: n/a (wires only).
// Backpressure: in_valid_i/in_ready_o upstream, out_valid_o/out_ready_i downstream.
// Ports: operands/op/op_mod/tag/flush and both handshakes; slave = the adder.
interface fphub_add_pipe_if
  import fphub_pkg::*;
#(
  parameter int WIDTH    = 16,
  parameter int TagWidth = 4
) ();

  logic [2:0][WIDTH-1:0] operands_i;
  operation_e            op_i;
  logic                  op_mod_i;
  logic [TagWidth-1:0]   tag_i;
  logic                  in_valid_i;
  logic                  in_ready_o;
  logic                  flush_i;
  logic [WIDTH-1:0]      result_o;
  status_t               status_o;
  logic [TagWidth-1:0]   tag_o;
  logic                  out_valid_o;
  logic                  out_ready_i;
  logic                  busy_o;

  modport master (
    output operands_i, op_i, op_mod_i, tag_i, in_valid_i, flush_i, out_ready_i,
    input  in_ready_o, result_o, status_o, tag_o, out_valid_o, busy_o
  );

  modport slave (
    input  operands_i, op_i, op_mod_i, tag_i, in_valid_i, flush_i, out_ready_i,
    output in_ready_o, result_o, status_o, tag_o, out_valid_o, busy_o
  );

endinterface

// File: rtl/FPHUB_adder.sv
// Combinational HUB floating-point adder core (X + Y -> Z, round-to-nearest by truncation).
// Latency: 0 cycles, purely combinational.
// Backpressure: none; Z follows X/Y whenever start is high, 0 otherwise.
// Ports: start, X, Y (1+E+M bits each), Z. Exponent 0 is treated as zero (no subnormals).
module FPHUB_adder #(
  parameter int E = 5,
  parameter int M = 10
) (
  input  logic         start,
  input  logic [E+M:0] X,
  input  logic [E+M:0] Y,
  output logic [E+M:0] Z
);

  // carry + hidden one + M fraction bits + implicit HUB LSB
  localparam int W = M + 3;

  logic         swap;
  logic [E+M:0] a, b;
  logic [E-1:0] ea, eb, d;
  logic [W-1:0] ma, mb, mbs, sum, norm;
  logic         unused_norm;
  int           p, er;

  // Order operands by magnitude so the subtraction never goes negative.
  assign swap = Y[E+M-1:0] > X[E+M-1:0];
  assign a    = swap ? Y : X;
  assign b    = swap ? X : Y;
  assign ea   = a[E+M-1:M];
  assign eb   = b[E+M-1:M];

  // HUB significands carry an always-one bit below the stored LSB.
  assign ma  = (ea == '0) ? '0 : {2'b01, a[M-1:0], 1'b1};
  assign mb  = (eb == '0) ? '0 : {2'b01, b[M-1:0], 1'b1};
  assign d   = ea - eb;
  assign mbs = (32'(d) >= 32'(W)) ? '0 : (mb >> d);
  assign sum = (a[E+M] ^ b[E+M]) ? (ma - mbs) : (ma + mbs);

  always_comb begin
    p    = -1;
    norm = '0;
    er   = 0;
    Z    = '0;
    for (int i = 0; i < W; i++) begin
      if (sum[i]) p = i;
    end
    if (p >= 0) begin
      norm = sum << (W - 1 - p);
      er   = int'(ea) + p - (W - 2);
      if (er >= (1 << E) - 1) begin
        Z = {a[E+M], {E{1'b1}}, {M{1'b0}}};
      end else if (er <= 0) begin
        Z = {a[E+M], {(E+M){1'b0}}};
      end else begin
        // Truncation drops the position of the new implicit HUB bit.
        Z = {a[E+M], E'(er), norm[W-2 -: M]};
      end
    end
    if (!start) Z = '0;
  end

  // Leading one and the bits below the kept fraction are implied, not stored.
  assign unused_norm = ^{norm[W-1], norm[W-M-2:0]};

endmodule

// File: rtl/fphub_pipe_stage.sv
// One elastic register slice: valid + payload, ready chained from downstream.
// Latency: 1 cycle.
// Backpressure: up_rdy = !valid || dn_rdy (combinational pass-through, no skid).
// Ports: clk_i, rst_ni, flush_i, up_vld/up_dat/up_rdy, dn_vld/dn_dat/dn_rdy.
module fphub_pipe_stage
  import fphub_pkg::*;
#(
  parameter type data_t = fphub_stage_t
) (
  input  logic  clk_i,
  input  logic  rst_ni,
  input  logic  flush_i,
  input  logic  up_vld,
  input  data_t up_dat,
  output logic  up_rdy,
  output logic  dn_vld,
  output data_t dn_dat,
  input  logic  dn_rdy
);

  logic  vld_q;
  data_t dat_q;

  assign up_rdy = !vld_q || dn_rdy;
  assign dn_vld = vld_q;
  assign dn_dat = dat_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      vld_q <= 1'b0;
      dat_q <= '0;
    end else begin
      // Flush wins over any load; payload is left as-is.
      if (flush_i) begin
        vld_q <= 1'b0;
      end else if (up_rdy) begin
        vld_q <= up_vld;
      end
      if (up_vld && up_rdy && !flush_i) begin
        dat_q <= up_dat;
      end
    end
  end

endmodule

// File: rtl/fphub_add_pipe.sv
// Pipelined HUB FP adder/subtractor with special-value handling, tag passthrough and flush.
// Latency: NumPipeRegs cycles (legal 1..8), one operation per cycle throughput.
// Backpressure: in_ready_o is combinational from out_ready_i through the stage chain; no skid.
// Ports: clk_i, rst_ni (async, active-low), bus (fphub_add_pipe_if.slave).
// Build option: define FPHUB_ADD_STATUS_EN to register computed NV/OF/NX flags;
// otherwise status_o is constant zero and no status flops exist.
module fphub_add_pipe
  import fphub_pkg::*;
#(
  parameter fp_format_e FpFormat    = FP16,
  parameter int         E           = exp_bits(FpFormat),
  parameter int         M           = man_bits(FpFormat),
  parameter int         WIDTH       = 1 + E + M,
  parameter int         NumPipeRegs = 2,
  parameter int         TagWidth    = 4
) (
  input logic             clk_i,
  input logic             rst_ni,
  fphub_add_pipe_if.slave bus
);

`ifdef FPHUB_ADD_STATUS_EN
  typedef struct packed {
    logic [WIDTH-1:0]    result;
    status_t             status;
    logic [TagWidth-1:0] tag;
  } stage_t;
`else
  typedef struct packed {
    logic [WIDTH-1:0]    result;
    logic [TagWidth-1:0] tag;
  } stage_t;
`endif

  localparam logic [WIDTH-1:0] CanonNan = WIDTH'(canon_nan(E, M));

  // ---------------- stage 0: sign flip, core, specials ----------------
  logic [WIDTH-1:0] x, y, z, res;
  logic             x_nan, y_nan, x_inf, y_inf;
  logic             nv, of;
  logic             unused_op0;
  stage_t           s0;

  assign x = bus.operands_i[1];
  assign y = {bus.operands_i[2][WIDTH-1] ^ bus.op_mod_i, bus.operands_i[2][WIDTH-2:0]};
  assign unused_op0 = ^bus.operands_i[0];

  FPHUB_adder #(.E(E), .M(M)) u_core (
    .start (1'b1),
    .X     (x),
    .Y     (y),
    .Z     (z)
  );

  assign x_nan = is_nan(64'(x), E, M);
  assign y_nan = is_nan(64'(y), E, M);
  assign x_inf = is_inf(64'(x), E, M);
  assign y_inf = is_inf(64'(y), E, M);

  always_comb begin
    res = z;
    nv  = 1'b0;
    of  = 1'b0;
    if (x_nan || y_nan) begin
      res = CanonNan;
    end else if (x_inf && y_inf && (x[WIDTH-1] != y[WIDTH-1])) begin
      res = CanonNan;
      nv  = 1'b1;
    end else if (x_inf) begin
      res = x;
    end else if (y_inf) begin
      res = y;
    end else if (bus.op_i != ADD) begin
      res = CanonNan;
      nv  = 1'b1;
    end else begin
      // Both finite: an all-ones exponent can only come from overflow.
      of = &z[WIDTH-2:M];
    end
  end

  always_comb begin
    s0        = '0;
    s0.result = res;
    s0.tag    = bus.tag_i;
`ifdef FPHUB_ADD_STATUS_EN
    s0.status.NV = nv;
    s0.status.OF = of;
    s0.status.NX = of;
`endif
  end

`ifndef FPHUB_ADD_STATUS_EN
  logic unused_flags;
  assign unused_flags = nv ^ of;
`endif

  // ---------------- stages 1..NumPipeRegs ----------------
  // Index k of vld/dat is the output of stage k; rdy[k] is the ready seen by stage k.
  logic [NumPipeRegs:0] vld;
  logic [NumPipeRegs:0] rdy;
  stage_t               dat [NumPipeRegs+1];

  assign vld[0]           = bus.in_valid_i;
  assign dat[0]           = s0;
  assign rdy[NumPipeRegs] = bus.out_ready_i;

  for (genvar k = 0; k < NumPipeRegs; k++) begin : g_stage
    fphub_pipe_stage #(.data_t(stage_t)) u_stage (
      .clk_i   (clk_i),
      .rst_ni  (rst_ni),
      .flush_i (bus.flush_i),
      .up_vld  (vld[k]),
      .up_dat  (dat[k]),
      .up_rdy  (rdy[k]),
      .dn_vld  (vld[k+1]),
      .dn_dat  (dat[k+1]),
      .dn_rdy  (rdy[k+1])
    );
  end

  assign bus.in_ready_o  = rdy[0];
  assign bus.out_valid_o = vld[NumPipeRegs];
  assign bus.result_o    = dat[NumPipeRegs].result;
  assign bus.tag_o       = dat[NumPipeRegs].tag;
  assign bus.busy_o      = |vld[NumPipeRegs:1];
`ifdef FPHUB_ADD_STATUS_EN
  assign bus.status_o    = dat[NumPipeRegs].status;
`else
  assign bus.status_o    = '0;
`endif

endmodule

// File: tb/tb_fphub_add_pipe.sv
// Directed bench for fphub_add_pipe (FP16, NumPipeRegs=2, TagWidth=4).
// Expected HUB sums are hand-derived: 2+1 -> 0x4200, 1+1 -> 0x4000, 1-1 -> 0x0000,
// 0x7BFF+0x7BFF overflows to 0x7C00.
module tb_fphub_add_pipe;
  import fphub_pkg::*;

`ifdef FPHUB_ADD_STATUS_EN
  localparam logic [4:0] ST_NV = 5'b10000;
  localparam logic [4:0] ST_OF = 5'b00101;
`else
  localparam logic [4:0] ST_NV = 5'b00000;
  localparam logic [4:0] ST_OF = 5'b00000;
`endif

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   vectors     = 0;
  int   miscompares = 0;

  always #5 clk = ~clk;

  fphub_add_pipe_if #(.WIDTH(16), .TagWidth(4)) bus ();

  fphub_add_pipe #(
    .FpFormat    (FP16),
    .NumPipeRegs (2),
    .TagWidth    (4)
  ) dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus    (bus)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic apply(input logic [15:0] x, input logic [15:0] y, input logic md,
                       input operation_e op, input logic [3:0] t);
    bus.operands_i[0] = 16'h0000;
    bus.operands_i[1] = x;
    bus.operands_i[2] = y;
    bus.op_mod_i      = md;
    bus.op_i          = op;
    bus.tag_i         = t;
    bus.in_valid_i    = 1'b1;
  endtask

  // Offer one op on an empty pipe and step to the cycle where it is at the output.
  task automatic run2(input logic [15:0] x, input logic [15:0] y, input logic md,
                      input operation_e op, input logic [3:0] t);
    apply(x, y, md, op, t);
    @(posedge clk); #1;
    bus.in_valid_i = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic chk_out(input string tag, input logic [15:0] r, input logic [4:0] s,
                         input logic [3:0] t);
    chk({tag, "_vld"}, 32'(bus.out_valid_o), 32'd1);
    chk({tag, "_res"}, 32'(bus.result_o), 32'(r));
    chk({tag, "_st"},  32'(bus.status_o), 32'(s));
    chk({tag, "_tag"}, 32'(bus.tag_o), 32'(t));
  endtask

  initial begin
    bus.operands_i  = '0;
    bus.op_i        = ADD;
    bus.op_mod_i    = 1'b0;
    bus.tag_i       = '0;
    bus.in_valid_i  = 1'b0;
    bus.flush_i     = 1'b0;
    bus.out_ready_i = 1'b1;

    // Reset held for 3 cycles
    repeat (3) @(posedge clk);
    #1;
    chk("rst_vld",  32'(bus.out_valid_o), 32'd0);
    chk("rst_busy", 32'(bus.busy_o), 32'd0);
    chk("rst_res",  32'(bus.result_o), 32'd0);
    chk("rst_st",   32'(bus.status_o), 32'd0);
    chk("rst_tag",  32'(bus.tag_o), 32'd0);
    chk("rst_rdy",  32'(bus.in_ready_o), 32'd1);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;

    // First op: latency of exactly two edges
    apply(16'h4000, 16'h3C00, 1'b0, ADD, 4'd5);
    chk("lat_rdy", 32'(bus.in_ready_o), 32'd1);
    @(posedge clk); #1;
    bus.in_valid_i = 1'b0;
    chk("lat_e1_vld",  32'(bus.out_valid_o), 32'd0);
    chk("lat_e1_busy", 32'(bus.busy_o), 32'd1);
    @(posedge clk); #1;
    chk_out("lat_e2", 16'h4200, 5'b0, 4'd5);
    @(posedge clk); #1;
    chk("lat_drain", 32'(bus.out_valid_o), 32'd0);

    // Back-to-back stream, tags 0..15
    for (int c = 0; c < 18; c++) begin
      if (c < 16) apply(16'h4000, 16'h3C00, 1'b0, ADD, 4'(c));
      else bus.in_valid_i = 1'b0;
      @(posedge clk); #1;
      if (c >= 1 && c <= 16) begin
        chk("stream_vld", 32'(bus.out_valid_o), 32'd1);
        chk("stream_tag", 32'(bus.tag_o), 32'(c - 1));
        chk("stream_rdy", 32'(bus.in_ready_o), 32'd1);
      end else begin
        chk("stream_idle", 32'(bus.out_valid_o), 32'd0);
      end
    end

    // Backpressure: two accepted, then full
    bus.out_ready_i = 1'b0;
    apply(16'h4000, 16'h3C00, 1'b0, ADD, 4'd1);
    chk("bp_rdy1", 32'(bus.in_ready_o), 32'd1);
    @(posedge clk); #1;
    apply(16'h3C00, 16'h3C00, 1'b0, ADD, 4'd2);
    chk("bp_rdy2", 32'(bus.in_ready_o), 32'd1);
    @(posedge clk); #1;
    apply(16'h3C00, 16'h3C00, 1'b1, ADD, 4'd3);
    chk("bp_full", 32'(bus.in_ready_o), 32'd0);
    chk_out("bp_head", 16'h4200, 5'b0, 4'd1);
    for (int i = 0; i < 2; i++) begin
      @(posedge clk); #1;
      chk("bp_hold_rdy", 32'(bus.in_ready_o), 32'd0);
      chk_out("bp_hold", 16'h4200, 5'b0, 4'd1);
    end
    bus.out_ready_i = 1'b1;
    #1;
    chk("bp_release_rdy", 32'(bus.in_ready_o), 32'd1);
    @(posedge clk); #1;
    chk_out("bp_out2", 16'h4000, 5'b0, 4'd2);
    apply(16'h7BFF, 16'h7BFF, 1'b0, ADD, 4'd4);
    @(posedge clk); #1;
    bus.in_valid_i = 1'b0;
    chk_out("bp_out3", 16'h0000, 5'b0, 4'd3);
    @(posedge clk); #1;
    chk_out("bp_out4_ovf", 16'h7C00, ST_OF, 4'd4);
    @(posedge clk); #1;
    chk("bp_empty_vld",  32'(bus.out_valid_o), 32'd0);
    chk("bp_empty_busy", 32'(bus.busy_o), 32'd0);

    // Special values
    run2(16'h7C00, 16'hFC00, 1'b0, ADD, 4'd6);
    chk_out("sp_inf_minf", 16'h7E00, ST_NV, 4'd6);
    run2(16'h7C00, 16'h3C00, 1'b0, ADD, 4'd7);
    chk_out("sp_inf_fin", 16'h7C00, 5'b0, 4'd7);
    run2(16'h7C00, 16'h7C00, 1'b1, ADD, 4'd8);
    chk_out("sp_inf_sub_inf", 16'h7E00, ST_NV, 4'd8);
    run2(16'h7D00, 16'h0000, 1'b0, ADD, 4'd9);
    chk_out("sp_nan", 16'h7E00, 5'b0, 4'd9);
    run2(16'h3C00, 16'hFC00, 1'b1, ADD, 4'd10);
    chk_out("sp_sub_minf", 16'h7C00, 5'b0, 4'd10);
    run2(16'h3C00, 16'h3C00, 1'b0, MUL, 4'd11);
    chk_out("sp_bad_op", 16'h7E00, ST_NV, 4'd11);
    @(posedge clk); #1;

    // Flush with two ops in flight and a same-cycle input handshake
    bus.out_ready_i = 1'b0;
    apply(16'h4000, 16'h3C00, 1'b0, ADD, 4'd12);
    @(posedge clk); #1;
    apply(16'h3C00, 16'h3C00, 1'b0, ADD, 4'd13);
    @(posedge clk); #1;
    chk("fl_busy_pre", 32'(bus.busy_o), 32'd1);
    apply(16'h3C00, 16'h3C00, 1'b0, ADD, 4'd14);
    bus.flush_i     = 1'b1;
    bus.out_ready_i = 1'b1;
    #1;
    chk("fl_hs_rdy", 32'(bus.in_ready_o), 32'd1);
    @(posedge clk); #1;
    bus.flush_i    = 1'b0;
    bus.in_valid_i = 1'b0;
    chk("fl_vld",  32'(bus.out_valid_o), 32'd0);
    chk("fl_busy", 32'(bus.busy_o), 32'd0);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk("fl_quiet", 32'(bus.out_valid_o), 32'd0);
    end

    // Asynchronous reset mid-stall
    bus.out_ready_i = 1'b0;
    run2(16'h4000, 16'h3C00, 1'b0, ADD, 4'd15);
    chk("ar_pre_vld", 32'(bus.out_valid_o), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("ar_vld",  32'(bus.out_valid_o), 32'd0);
    chk("ar_busy", 32'(bus.busy_o), 32'd0);
    chk("ar_res",  32'(bus.result_o), 32'd0);
    chk("ar_tag",  32'(bus.tag_o), 32'd0);
    chk("ar_rdy",  32'(bus.in_ready_o), 32'd1);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    chk("ar_post_vld", 32'(bus.out_valid_o), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
